apb_fsm_controller: RTL
=======================

# apb_fsm_controller

Bridge-side APB sequencer of the AHB-to-APB bridge. Consumes the pipelined AHB transfer information produced by the AHB slave interface (valid, registered write flag, staged addresses and data) and drives the APB master signals through correct SETUP/ENABLE phases. Supports back-to-back and pipelined writes. Stalls the AHB master by dropping `hreadyout` during APB setup phases.

## Interface
- `NUM_SLV`, 3: number of APB peripherals; width of `pselx`.
- `AW`, 32: address width.
- `DW`, 32: data width.

- `hclk`  in  1  bridge clock; all state updates on rising edge.
- `hresetn`  in  1  asynchronous, active-low reset.
- `valid`  in  1  current AHB address phase is a decoded, in-range NONSEQ/SEQ transfer.
- `hwrite`  in  1  write flag of current AHB address phase.
- `hwritereg`  in  1  write flag of previous address phase (one-cycle registered).
- `haddr`, `haddr1`, `haddr2`  in  AW  current, 1-cycle-delayed and 2-cycle-delayed AHB address.
- `hwdata`, `hwdata1`  in  DW  current and 1-cycle-delayed AHB write data.
- `pselx`  out  NUM_SLV  one-hot APB peripheral select.
- `penable`  out  1  APB enable phase.
- `pwrite`  out  1  APB direction.
- `paddr`  out  AW  APB address.
- `pwdata`  out  DW  APB write data.
- `hreadyout`  out  1  to AHB; 0 stalls the master.

## Operation
- States: IDLE, WWAIT, READ, RENABLE, WRITE, WRITEP, WENABLE, WENABLEP.
- IDLE: `valid&hwrite` -> WWAIT; `valid&!hwrite` -> READ; else stay.
- WWAIT (write data phase): `valid` -> WRITEP; else -> WRITE.
- READ (setup): -> RENABLE unconditionally.
- WRITE (setup): `valid` -> WENABLEP; else -> WENABLE.
- WRITEP (setup, pipelined): -> WENABLEP unconditionally.
- RENABLE, WENABLE: `valid&hwrite` -> WWAIT; `valid&!hwrite` -> READ; else IDLE.
- WENABLEP: `hwritereg&valid` -> WRITEP; `hwritereg&!valid` -> WRITE; `!hwritereg` -> READ.
- All APB outputs registered. Load values on the edge that enters a state:
  - entering READ: `paddr<=haddr`, `pwrite<=0`.
  - entering WRITE/WRITEP from WWAIT: `paddr<=haddr1`, `pwdata<=hwdata`.
  - entering WRITE/WRITEP from WENABLEP: `paddr<=haddr2`, `pwdata<=hwdata1`.
  - `pwrite<=1` on any write setup.
  - `pselx<=sel_decode(next paddr)`.
- `pselx` held through the following ENABLE state. `pselx<=0` entering IDLE or WWAIT.
- `penable` is 1 only in RENABLE, WENABLE and WENABLEP.
- `hreadyout` is 0 in READ, WRITE and WRITEP; 1 in every other state.
- `sel_decode`:
  - 0x8000_0000–0x83FF_FFFF -> 001.
  - 0x8400_0000–0x87FF_FFFF -> 010.
  - 0x8800_0000–0x8BFF_FFFF -> 100.
  - otherwise 000. Upstream `valid` already excludes such addresses.
- No PREADY/PSLVERR: every APB access is exactly one SETUP plus one ENABLE cycle.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, `pselx=0`, `penable=0`, `pwrite=0`, `paddr=0`, `pwdata=0`, `hreadyout=1`.
- Read latency: `valid` sampled in IDLE at edge N. SETUP is visible cycle N+1. ENABLE is visible at N+2, with `hreadyout=1`; the AHB side returns `prdata` then.
- Single write: edge N `valid` -> WWAIT at N+1 -> SETUP at N+2 -> ENABLE at N+3.
- Back-to-back writes alternate WRITEP/WENABLEP. Each APB write takes 2 cycles with `hreadyout` low 1 of every 2.
- Write followed by read: WENABLEP -> READ. The read uses `haddr` current at that edge.
- `valid` low in WRITE: finishes through WENABLE, then IDLE. No spurious APB cycle.
- Reset mid-transfer: outputs drop immediately to reset values; the in-flight APB access is abandoned.
- `pselx` never changes between a SETUP cycle and its ENABLE cycle. `penable` never rises without `pselx` nonzero in the prior cycle.

## Structure
- Package `bridge_pkg`:
  - state enum (3-bit encoding);
  - the three peripheral base/limit constants;
  - `sel_decode` function.
- The AHB slave interface imports the same package for its own decode.
- Single module; no sub-module needed. The FSM next-state logic and output registers live in one file.

## Test plan
- Reset: hold `hresetn=0` 2 cycles -> all outputs at reset values, `hreadyout=1`; assert reset again mid-WRITE -> outputs clear asynchronously.
- Single read: `valid=1`, `hwrite=0`, `haddr=0x8400_0020` for one cycle from IDLE -> next cycle `pselx=010`, `penable=0`, `paddr=0x8400_0020`, `hreadyout=0`; following cycle `penable=1`, `hreadyout=1`; then IDLE with `pselx=0`.
- Single write: `haddr=0x8000_0010`, then `hwdata=0x1234_5678` with `valid` low -> `paddr=0x8000_0010`, `pwdata=0x1234_5678`, `pwrite=1`, `pselx=001` at N+2; `penable=1` at N+3.
- Burst of 3 writes: addresses 0x8800_0000/04/08 with data A/B/C -> three SETUP/ENABLE pairs in order with matching address/data, `pselx=100`; `hreadyout` toggles 0/1.
- Write then read: write to 0x8000_0010, then read 0x8400_0020 -> WENABLEP -> READ; the read SETUP shows `pwrite=0`, `pselx=010`.
- Idle traffic: `valid=0` for 10 cycles -> state IDLE, `pselx=0`, `penable=0` throughout.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: sequencer states and peripheral map.
package bridge_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned NUM_PERIPH = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WWAIT    = 3'd1,
    ST_READ     = 3'd2,
    ST_RENABLE  = 3'd3,
    ST_WRITE    = 3'd4,
    ST_WRITEP   = 3'd5,
    ST_WENABLE  = 3'd6,
    ST_WENABLEP = 3'd7
  } state_t;

  localparam logic [ADDR_W-1:0] SLV0_BASE  = 32'h8000_0000;
  localparam logic [ADDR_W-1:0] SLV0_LIMIT = 32'h83FF_FFFF;
  localparam logic [ADDR_W-1:0] SLV1_BASE  = 32'h8400_0000;
  localparam logic [ADDR_W-1:0] SLV1_LIMIT = 32'h87FF_FFFF;
  localparam logic [ADDR_W-1:0] SLV2_BASE  = 32'h8800_0000;
  localparam logic [ADDR_W-1:0] SLV2_LIMIT = 32'h8BFF_FFFF;

  // One-hot peripheral select; out-of-map addresses select nothing.
  function automatic logic [NUM_PERIPH-1:0] sel_decode(input logic [ADDR_W-1:0] addr);
    logic [NUM_PERIPH-1:0] sel;
    sel = '0;
    if (addr >= SLV0_BASE && addr <= SLV0_LIMIT) sel = NUM_PERIPH'(3'b001);
    else if (addr >= SLV1_BASE && addr <= SLV1_LIMIT) sel = NUM_PERIPH'(3'b010);
    else if (addr >= SLV2_BASE && addr <= SLV2_LIMIT) sel = NUM_PERIPH'(3'b100);
    return sel;
  endfunction

endpackage

// File: rtl/apb_fsm_controller.sv
// Bridge-side APB sequencer: turns pipelined AHB transfers into APB SETUP/ENABLE
// pairs and stalls the AHB master during each SETUP cycle.
module apb_fsm_controller
  import bridge_pkg::*;
#(
  parameter int unsigned NUM_SLV = 3,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic               valid,
  input  logic               hwrite,
  input  logic               hwritereg,
  input  logic [AW-1:0]      haddr,
  input  logic [AW-1:0]      haddr1,
  input  logic [AW-1:0]      haddr2,
  input  logic [DW-1:0]      hwdata,
  input  logic [DW-1:0]      hwdata1,
  output logic [NUM_SLV-1:0] pselx,
  output logic               penable,
  output logic               pwrite,
  output logic [AW-1:0]      paddr,
  output logic [DW-1:0]      pwdata,
  output logic               hreadyout
);

  state_t state, state_nxt;
  logic [AW-1:0] setup_addr_c;
  logic [DW-1:0] setup_data_c;

  function automatic logic [NUM_SLV-1:0] decode(input logic [AW-1:0] addr);
    return NUM_SLV'(sel_decode(ADDR_W'(addr)));
  endfunction

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (valid && hwrite)       state_nxt = ST_WWAIT;
        else if (valid && !hwrite) state_nxt = ST_READ;
      end
      ST_WWAIT:    state_nxt = valid ? ST_WRITEP : ST_WRITE;
      ST_READ:     state_nxt = ST_RENABLE;
      ST_WRITE:    state_nxt = valid ? ST_WENABLEP : ST_WENABLE;
      ST_WRITEP:   state_nxt = ST_WENABLEP;
      ST_RENABLE, ST_WENABLE: begin
        if (valid && hwrite)       state_nxt = ST_WWAIT;
        else if (valid && !hwrite) state_nxt = ST_READ;
        else                       state_nxt = ST_IDLE;
      end
      ST_WENABLEP: begin
        if (!hwritereg)  state_nxt = ST_READ;
        else if (valid)  state_nxt = ST_WRITEP;
        else             state_nxt = ST_WRITE;
      end
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // A pipelined write re-entering setup is two beats behind the AHB address.
  always_comb begin
    setup_addr_c = haddr1;
    setup_data_c = hwdata;
    if (state == ST_WENABLEP) begin
      setup_addr_c = haddr2;
      setup_data_c = hwdata1;
    end
  end

  // State and APB output registers, loaded on the edge that enters each state.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= ST_IDLE;
      pselx     <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      hreadyout <= 1'b1;
    end else begin
      state <= state_nxt;
      unique case (state_nxt)
        ST_IDLE, ST_WWAIT: begin
          pselx     <= '0;
          penable   <= 1'b0;
          hreadyout <= 1'b1;
        end
        ST_READ: begin
          paddr     <= haddr;
          pwrite    <= 1'b0;
          pselx     <= decode(haddr);
          penable   <= 1'b0;
          hreadyout <= 1'b0;
        end
        ST_WRITE, ST_WRITEP: begin
          paddr     <= setup_addr_c;
          pwdata    <= setup_data_c;
          pwrite    <= 1'b1;
          pselx     <= decode(setup_addr_c);
          penable   <= 1'b0;
          hreadyout <= 1'b0;
        end
        default: begin
          penable   <= 1'b1;
          hreadyout <= 1'b1;
        end
      endcase
    end
  end

endmodule
